inv_key_sched_192: RTL and testbench

- Reverse AES-192 key schedule for the decryption datapath.
- Loaded with the last six expanded-key words w[46..51]. Regenerates earlier words on the fly with the inverse recurrence w[i-6] = w[i] ^ T(w[i-1]).
- Delivers round keys 12 down to 0 over a valid/ready handshake, so no 52-word key memory is needed.
- Sits between the key-load register block and the inverse-cipher round core.

---
 rtl/inv_key_sched_192_if.sv | 13 +
 rtl/inv_key_sched_192.sv | 81 ++++++++
 tb/tb_inv_key_sched_192.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/inv_key_sched_192_if.sv
// inv_key_sched_192_if: load and round-key handshake bundle for the reverse AES-192 key schedule
interface inv_key_sched_192_if;
  logic start;
  logic [191:0] key_in;
  logic rk_ready;
  logic rk_valid;
  logic [127:0] rk_out;
  logic [3:0] rk_round;
  logic busy;
  logic done;
  modport master (output start, key_in, rk_ready, input rk_valid, rk_out, rk_round, busy, done);
  modport slave (input start, key_in, rk_ready, output rk_valid, rk_out, rk_round, busy, done);
endinterface

// File: rtl/inv_key_sched_192.sv
// inv_key_sched_192: regenerates AES-192 round keys 12..0 from w[46..51] with a six-word sliding window
module inv_key_sched_192 (
  input logic clk,
  input logic rst,
  inv_key_sched_192_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, STEP = 2'd2;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction
  logic [1:0] state;
  logic [31:0] w [6];
  logic [5:0] j;
  logic [3:0] r;
  logic [2:0] ph;
  logic [7:0] rc;
  logic [127:0] last;
  logic done_q;
  logic [31:0] rot, t, nw;
  logic [127:0] cand;
  assign rot = {w[4][23:0], w[4][31:24]};
  // ph tracks (j+5) mod 6; rc walks 80..01 as the rcon index falls
  assign t = ph == 3'd0 ? {sb(rot[31:24]) ^ rc, sb(rot[23:16]), sb(rot[15:8]), sb(rot[7:0])} : w[4];
  assign nw = w[5] ^ t;
  assign cand = r == 4'd12 ? {w[2], w[3], w[4], w[5]} : {w[0], w[1], w[2], w[3]};
  assign bus.rk_valid = state == HOLD;
  assign bus.rk_out = state == HOLD ? cand : last;
  assign bus.rk_round = r;
  assign bus.busy = state != IDLE;
  assign bus.done = done_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      for (int k = 0; k < 6; k++) w[k] <= '0;
      j <= '0;
      r <= '0;
      ph <= '0;
      rc <= '0;
      last <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE && bus.start) begin
        for (int k = 0; k < 6; k++) w[k] <= bus.key_in[191 - 32*k -: 32];
        j <= 6'd46;
        r <= 4'd12;
        ph <= 3'd3;
        rc <= 8'h80;
        state <= HOLD;
      end else if (state == HOLD) begin
        last <= cand;
        if (bus.rk_ready) begin
          if (r == 4'd0) begin
            state <= IDLE;
            done_q <= 1'b1;
          end else begin
            r <= r - 4'd1;
            state <= STEP;
          end
        end
      end else if (state == STEP) begin
        w[0] <= nw;
        for (int k = 1; k < 6; k++) w[k] <= w[k-1];
        j <= j - 6'd1;
        ph <= ph == 3'd0 ? 3'd5 : ph - 3'd1;
        if (ph == 3'd0) rc <= rc >> 1;
        if (j - 6'd1 == {r, 2'b00}) state <= HOLD;
      end
    end
  end
endmodule

// File: tb/tb_inv_key_sched_192.sv
// tb_inv_key_sched_192: checks the reverse key schedule against a forward AES-192 expansion model
module tb_inv_key_sched_192;
  logic clk = 1'b0;
  logic rst = 1'b1;
  inv_key_sched_192_if bus();
  inv_key_sched_192 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0, errors = 0, done_cnt = 0;
  logic [31:0] ew [52];
  logic [7:0] sbox [256];
  logic [127:0] seen [13];
  logic [127:0] fips_seen [13];
  localparam logic [191:0] FIPS_KEY = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b} << n;
    return d[15:8];
  endfunction

  // S-box from first principles: multiplicative inverse in GF(2^8) then the affine map
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand(input logic [191:0] key);
    for (int i = 0; i < 6; i++) ew[i] = key[191 - 32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      logic [31:0] t = ew[i-1];
      if (i % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t ^= {8'h01 << (i/6 - 1), 24'h0};
      end
      ew[i] = ew[i-6] ^ t;
    end
  endtask

  function automatic logic [127:0] exp_rk(input int r);
    return {ew[4*r], ew[4*r+1], ew[4*r+2], ew[4*r+3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.done) done_cnt++;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic run(input logic [191:0] key, input int bp_round, input bit rnd_rdy, input bit noise);
    logic [127:0] hold_out;
    logic rdy;
    int n;
    expand(key);
    done_cnt = 0;
    bus.key_in = {ew[46], ew[47], ew[48], ew[49], ew[50], ew[51]};
    bus.rk_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    chk("valid_after_start", bus.rk_valid, 1);
    for (int r = 12; r >= 0; r--) begin
      n = 0;
      while (!bus.rk_valid && n < 20) begin
        bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.rk_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
        n++;
      end
      chk("valid_timeout", bus.rk_valid, 1);
      if (r < 12) chk("latency", 128'(n + 1), r == 11 ? 128'd3 : 128'd5);
      chk("rk_round", bus.rk_round, 128'(r));
      chk("rk_out", bus.rk_out, exp_rk(r));
      seen[r] = bus.rk_out;
      hold_out = bus.rk_out;
      n = 0;
      do begin
        bus.rk_ready = (r == bp_round && n < 7) ? 1'b0 : rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        rdy = bus.rk_ready;
        tick();
        n++;
        if (!rdy) begin
          chk("stall_valid", bus.rk_valid, 1);
          chk("stall_out", bus.rk_out, hold_out);
          chk("stall_round", bus.rk_round, 128'(r));
        end
      end while (!rdy && n < 60);
      chk("hs_timeout", rdy, 1);
      if (r == 0) begin
        bus.start = 1'b0;
        chk("done_pulse", bus.done, 1);
        chk("busy_fall", bus.busy, 0);
        chk("valid_idle", bus.rk_valid, 0);
      end
      bus.rk_ready = 1'b1;
    end
    bus.start = 1'b0;
    tick();
    tick();
    chk("done_once", 128'(done_cnt), 1);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    build_sbox();
    bus.start = 1'b0;
    bus.key_in = '0;
    bus.rk_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", bus.rk_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_out", bus.rk_out, 0);
    chk("rst_round", bus.rk_round, 0);
    rst = 1'b0;
    tick();
    run(FIPS_KEY, -1, 1'b0, 1'b0);
    chk("fips_r12", seen[12], 128'he98ba06f448c773c8ecc720401002202);
    chk("fips_r2", seen[2], 128'hec12068e6c827f6b0e7a95b95c56fec2);
    chk("fips_r1", seen[1], 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    chk("fips_r0", seen[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
    fips_seen = seen;
    run(FIPS_KEY, 8, 1'b0, 1'b0);
    run(192'h0, -1, 1'b0, 1'b0);
    chk("zero_r0", seen[0], 128'h0);
    chk("zero_r1", seen[1], 128'h00000000000000006263636362636363);
    run(FIPS_KEY, -1, 1'b0, 1'b1);
    for (int r = 0; r < 13; r++) chk("noise_same", seen[r], fips_seen[r]);
    repeat (4) begin
      run({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
          $urandom_range(0, 12), 1'b1, 1'($urandom_range(0, 1)));
    end
    expand({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
    bus.key_in = {ew[46], ew[47], ew[48], ew[49], ew[50], ew[51]};
    bus.rk_ready = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (19) tick();
    done_cnt = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", bus.rk_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    repeat (3) tick();
    chk("mid_rst_no_done", 128'(done_cnt), 0);
    bus.rk_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart_valid", bus.rk_valid, 1);
    chk("restart_round", bus.rk_round, 12);
    chk("restart_out", bus.rk_out, exp_rk(12));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    run({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, 3, 1'b0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
